wb_cmd_engine: RTL and testbench



---
 rtl/wb_cmd_engine.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_wb_cmd_engine.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_engine.sv
// -----------------------------------------------------------------------------
// wb_cmd_engine
//
// Queued Wishbone master. Commands (WRITE, READ, IRQ_READ) are pushed into a
// command FIFO and executed one at a time on the Wishbone master port. Each
// bus access has an ack timeout. Every command yields exactly one entry in a
// first-word-fall-through response FIFO. That entry carries the read data,
// the timeout flag and a NAK flag decoded from the status byte of an
// IRQ_READ.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   cmd_valid_i/ready_o     command handshake (ready = command FIFO not full)
//   cmd_op_i                0=WRITE 1=READ 2=IRQ_READ 3=READ
//   cmd_adr_i, cmd_dat_i    command address / write data
//   rsp_valid_o/ready_i     response handshake (head shown combinationally)
//   rsp_dat_o/err_o/nak_o   response payload
//   busy_o                  engine active or commands still queued
//   irq_i                   level interrupt awaited by IRQ_READ
//   cyc_o stb_o we_o adr_o dat_o ack_i dat_i   Wishbone master port
// -----------------------------------------------------------------------------
module wb_cmd_engine #(
  parameter int                    ADDR_WIDTH  = 2,
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    CMD_DEPTH   = 8,
  parameter int                    RSP_DEPTH   = 8,
  parameter int                    ACK_TIMEOUT = 255,
  parameter logic [ADDR_WIDTH-1:0] IRQ_RD_ADDR = 2'd2,
  parameter logic [DATA_WIDTH-1:0] NAK_MASK    = 8'h40
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [DATA_WIDTH-1:0] cmd_dat_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  rsp_nak_o,
  output logic                  busy_o,
  input  logic                  irq_i,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic                  ack_i,
  input  logic [DATA_WIDTH-1:0] dat_i
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam int TW  = $clog2(ACK_TIMEOUT + 1);
  localparam int RW  = DATA_WIDTH + 2;

  // Counter value on the last BUS cycle allowed without an ack.
  localparam logic [TW-1:0]  TO_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0]  TO_ONE   = TW'(1);
  localparam logic [CAW:0]   CPTR_ONE = (CAW + 1)'(1);
  localparam logic [RAW:0]   RPTR_ONE = (RAW + 1)'(1);
  localparam logic [1:0]     OP_WRITE = 2'd0;
  localparam logic [1:0]     OP_IRQ   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_IRQ = 3'd1,
    ST_BUS      = 3'd2,
    ST_GAP      = 3'd3,
    ST_RESP     = 3'd4
  } state_t;

  state_t state, state_next;

  // Command FIFO storage and pointers (extra MSB distinguishes full/empty).
  logic [1:0]            cmd_op_mem  [CMD_DEPTH];
  logic [ADDR_WIDTH-1:0] cmd_adr_mem [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] cmd_dat_mem [CMD_DEPTH];
  logic [CAW:0]          cmd_wr_ptr, cmd_rd_ptr;
  logic                  cmd_empty, cmd_full, cmd_push, cmd_pop;
  logic [1:0]            head_op;
  logic [ADDR_WIDTH-1:0] head_adr;
  logic [DATA_WIDTH-1:0] head_dat;

  // Response FIFO storage and pointers; entry is {dat, err, nak}.
  logic [RW-1:0]         rsp_mem [RSP_DEPTH];
  logic [RAW:0]          rsp_wr_ptr, rsp_rd_ptr;
  logic                  rsp_empty, rsp_full, rsp_push, rsp_pop;
  logic [RW-1:0]         rsp_head;

  // Bus and result registers with their next-state values.
  logic                  bus_cyc, bus_cyc_next;
  logic                  bus_we, bus_we_next;
  logic [ADDR_WIDTH-1:0] bus_adr, bus_adr_next;
  logic [DATA_WIDTH-1:0] bus_dat, bus_dat_next;
  logic [TW-1:0]         to_cnt, to_cnt_next;
  logic                  cur_irq, cur_irq_next;
  logic [DATA_WIDTH-1:0] res_dat, res_dat_next;
  logic                  res_err, res_err_next;
  logic                  res_nak, res_nak_next;

  assign cmd_empty = (cmd_wr_ptr == cmd_rd_ptr);
  assign cmd_full  = (cmd_wr_ptr[CAW] != cmd_rd_ptr[CAW]) &&
                     (cmd_wr_ptr[CAW-1:0] == cmd_rd_ptr[CAW-1:0]);
  assign rsp_empty = (rsp_wr_ptr == rsp_rd_ptr);
  assign rsp_full  = (rsp_wr_ptr[RAW] != rsp_rd_ptr[RAW]) &&
                     (rsp_wr_ptr[RAW-1:0] == rsp_rd_ptr[RAW-1:0]);

  // Readiness reflects occupancy at the start of the cycle, so a pop in the
  // same cycle does not open a slot until the next one.
  assign cmd_ready_o = !cmd_full;
  assign cmd_push    = cmd_valid_i && !cmd_full;
  assign rsp_valid_o = !rsp_empty;
  assign rsp_pop     = !rsp_empty && rsp_ready_i;
  assign busy_o      = (state != ST_IDLE) || !cmd_empty;

  assign head_op  = cmd_op_mem[cmd_rd_ptr[CAW-1:0]];
  assign head_adr = cmd_adr_mem[cmd_rd_ptr[CAW-1:0]];
  assign head_dat = cmd_dat_mem[cmd_rd_ptr[CAW-1:0]];
  assign rsp_head = rsp_mem[rsp_rd_ptr[RAW-1:0]];

  assign cyc_o = bus_cyc;
  assign stb_o = bus_cyc;
  assign we_o  = bus_we;
  assign adr_o = bus_adr;
  assign dat_o = bus_dat;

  // Response head presented combinationally; forced to zero while empty.
  always_comb begin
    if (rsp_empty) begin
      rsp_dat_o = {DATA_WIDTH{1'b0}};
      rsp_err_o = 1'b0;
      rsp_nak_o = 1'b0;
    end else begin
      rsp_dat_o = rsp_head[RW-1:2];
      rsp_err_o = rsp_head[1];
      rsp_nak_o = rsp_head[0];
    end
  end

  // Next-state and bus/result next values for the command sequencer.
  always_comb begin
    state_next   = state;
    cmd_pop      = 1'b0;
    rsp_push     = 1'b0;
    bus_cyc_next = bus_cyc;
    bus_we_next  = bus_we;
    bus_adr_next = bus_adr;
    bus_dat_next = bus_dat;
    to_cnt_next  = to_cnt;
    cur_irq_next = cur_irq;
    res_dat_next = res_dat;
    res_err_next = res_err;
    res_nak_next = res_nak;

    case (state)
      ST_IDLE: begin
        // Popping only with response space guarantees RESP can always push,
        // since nothing else fills the response FIFO while a command is
        // in flight.
        if (!cmd_empty && !rsp_full) begin
          cmd_pop      = 1'b1;
          to_cnt_next  = {TW{1'b0}};
          res_dat_next = {DATA_WIDTH{1'b0}};
          res_err_next = 1'b0;
          res_nak_next = 1'b0;
          cur_irq_next = (head_op == OP_IRQ);
          if (head_op == OP_IRQ) begin
            state_next = ST_WAIT_IRQ;
          end else begin
            state_next   = ST_BUS;
            bus_cyc_next = 1'b1;
            bus_we_next  = (head_op == OP_WRITE);
            bus_adr_next = head_adr;
            bus_dat_next = head_dat;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end

      ST_WAIT_IRQ: begin
        if (irq_i) begin
          state_next   = ST_BUS;
          bus_cyc_next = 1'b1;
          bus_we_next  = 1'b0;
          bus_adr_next = IRQ_RD_ADDR;
          bus_dat_next = {DATA_WIDTH{1'b0}};
          to_cnt_next  = {TW{1'b0}};
        end else begin
          state_next = ST_WAIT_IRQ;
        end
      end

      ST_BUS: begin
        if (ack_i) begin
          state_next   = ST_GAP;
          bus_cyc_next = 1'b0;
          bus_we_next  = 1'b0;
          if (bus_we) begin
            res_dat_next = {DATA_WIDTH{1'b0}};
            res_nak_next = 1'b0;
          end else begin
            res_dat_next = dat_i;
            res_nak_next = cur_irq && ((dat_i & NAK_MASK) != {DATA_WIDTH{1'b0}});
          end
        end else if (to_cnt == TO_LAST) begin
          // This cycle completes ACK_TIMEOUT cycles without an ack.
          state_next   = ST_GAP;
          bus_cyc_next = 1'b0;
          bus_we_next  = 1'b0;
          res_err_next = 1'b1;
          res_dat_next = {DATA_WIDTH{1'b0}};
          res_nak_next = 1'b0;
        end else begin
          to_cnt_next = to_cnt + TO_ONE;
        end
      end

      ST_GAP: begin
        state_next = ST_RESP;
      end

      ST_RESP: begin
        rsp_push   = 1'b1;
        state_next = ST_IDLE;
      end

      default: begin
        state_next   = ST_IDLE;
        bus_cyc_next = 1'b0;
        bus_we_next  = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered bus outputs, timeout counter and result of the current command.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus_cyc <= 1'b0;
      bus_we  <= 1'b0;
      bus_adr <= {ADDR_WIDTH{1'b0}};
      bus_dat <= {DATA_WIDTH{1'b0}};
      to_cnt  <= {TW{1'b0}};
      cur_irq <= 1'b0;
      res_dat <= {DATA_WIDTH{1'b0}};
      res_err <= 1'b0;
      res_nak <= 1'b0;
    end else begin
      bus_cyc <= bus_cyc_next;
      bus_we  <= bus_we_next;
      bus_adr <= bus_adr_next;
      bus_dat <= bus_dat_next;
      to_cnt  <= to_cnt_next;
      cur_irq <= cur_irq_next;
      res_dat <= res_dat_next;
      res_err <= res_err_next;
      res_nak <= res_nak_next;
    end
  end

  // FIFO pointers; reset empties both queues and drops any in-flight command.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_wr_ptr <= {(CAW + 1){1'b0}};
      cmd_rd_ptr <= {(CAW + 1){1'b0}};
      rsp_wr_ptr <= {(RAW + 1){1'b0}};
      rsp_rd_ptr <= {(RAW + 1){1'b0}};
    end else begin
      if (cmd_push) begin
        cmd_wr_ptr <= cmd_wr_ptr + CPTR_ONE;
      end
      if (cmd_pop) begin
        cmd_rd_ptr <= cmd_rd_ptr + CPTR_ONE;
      end
      if (rsp_push) begin
        rsp_wr_ptr <= rsp_wr_ptr + RPTR_ONE;
      end
      if (rsp_pop) begin
        rsp_rd_ptr <= rsp_rd_ptr + RPTR_ONE;
      end
    end
  end

  // FIFO storage writes; contents need no reset because the pointers gate use.
  always_ff @(posedge clk_i) begin
    if (cmd_push) begin
      cmd_op_mem[cmd_wr_ptr[CAW-1:0]]  <= cmd_op_i;
      cmd_adr_mem[cmd_wr_ptr[CAW-1:0]] <= cmd_adr_i;
      cmd_dat_mem[cmd_wr_ptr[CAW-1:0]] <= cmd_dat_i;
    end
    if (rsp_push) begin
      rsp_mem[rsp_wr_ptr[RAW-1:0]] <= {res_dat, res_err, res_nak};
    end
  end

endmodule

// File: tb/tb_wb_cmd_engine.sv
// -----------------------------------------------------------------------------
// tb_wb_cmd_engine
//
// Directed bench for wb_cmd_engine (CMD_DEPTH=4, RSP_DEPTH=2, ACK_TIMEOUT=4).
// A small Wishbone slave model answers with a combinational ack, either from a
// 4-entry memory or from a sequence value {adr, read_index}. Expected responses
// are queued when each command is accepted. A monitor pops and compares them
// as the DUT hands them over, and it also records every cyc_o pulse (first-cycle
// attributes, length, and idle gap before it).
// -----------------------------------------------------------------------------
module tb_wb_cmd_engine;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [1:0] cmd_op_i;
  logic [1:0] cmd_adr_i;
  logic [7:0] cmd_dat_i;
  logic       rsp_valid_o;
  logic       rsp_ready_i;
  logic [7:0] rsp_dat_o;
  logic       rsp_err_o;
  logic       rsp_nak_o;
  logic       busy_o;
  logic       irq_i;
  logic       cyc_o, stb_o, we_o;
  logic [1:0] adr_o;
  logic [7:0] dat_o;
  logic       ack_i;
  logic [7:0] dat_i;

  // Slave model controls.
  logic       slave_en;
  logic       seq_mode;
  logic [7:0] smem [4];
  logic [5:0] seq;

  int tests = 0;
  int fails = 0;

  logic [9:0]  exp_q [$];   // {dat, err, nak}
  logic [10:0] bus_q [$];   // {we, adr, dat} at the first cycle of each pulse
  int          len_q [$];
  int          gap_q [$];
  int          high_cnt = 0;
  int          low_cnt = 0;
  logic        cyc_prev = 1'b0;

  wb_cmd_engine #(
    .ADDR_WIDTH (2),
    .DATA_WIDTH (8),
    .CMD_DEPTH  (4),
    .RSP_DEPTH  (2),
    .ACK_TIMEOUT(4),
    .IRQ_RD_ADDR(2'd2),
    .NAK_MASK   (8'h40)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_op_i   (cmd_op_i),
    .cmd_adr_i  (cmd_adr_i),
    .cmd_dat_i  (cmd_dat_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o  (rsp_dat_o),
    .rsp_err_o  (rsp_err_o),
    .rsp_nak_o  (rsp_nak_o),
    .busy_o     (busy_o),
    .irq_i      (irq_i),
    .cyc_o      (cyc_o),
    .stb_o      (stb_o),
    .we_o       (we_o),
    .adr_o      (adr_o),
    .dat_o      (dat_o),
    .ack_i      (ack_i),
    .dat_i      (dat_i)
  );

  always #5 clk = ~clk;

  assign ack_i = slave_en && cyc_o && stb_o;
  assign dat_i = seq_mode ? {adr_o, seq} : smem[adr_o];

  // Slave storage and read sequence counter.
  always @(posedge clk) begin
    if (rst_i) begin
      for (int k = 0; k < 4; k++) smem[k] <= 8'h00;
    end else if (ack_i && we_o) begin
      smem[adr_o] <= dat_o;
    end
    if (!seq_mode) seq <= 6'd0;
    else if (ack_i && !we_o) seq <= seq + 6'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Bus pulse recorder and response scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (cyc_o && !cyc_prev) begin
      bus_q.push_back({we_o, adr_o, dat_o});
      gap_q.push_back(low_cnt);
      high_cnt <= 1;
    end else if (cyc_o) begin
      high_cnt <= high_cnt + 1;
    end
    if (!cyc_o && cyc_prev) len_q.push_back(high_cnt);
    low_cnt  <= cyc_o ? 0 : low_cnt + 1;
    cyc_prev <= cyc_o;
    if (rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
      else check("rsp", {22'd0, rsp_dat_o, rsp_err_o, rsp_nak_o}, {22'd0, exp_q.pop_front()});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [1:0] adr, input logic [7:0] dat);
    int n = 0;
    while (!cmd_ready_o && n < 100) begin
      step(1);
      n++;
    end
    if (n >= 100) check("cmd_ready_wait", {31'd0, cmd_ready_o}, 32'd1);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    step(1);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_o || rsp_valid_o || exp_q.size() != 0) && n < 300) begin
      step(1);
      n++;
    end
    if (n >= 300) check("wait_idle", 32'd0, 32'd1);
  endtask

  task automatic clear_mon();
    bus_q.delete();
    len_q.delete();
    gap_q.delete();
  endtask

  initial begin
    int n;
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = 2'd0; cmd_adr_i = 2'd0; cmd_dat_i = 8'd0;
    rsp_ready_i = 1'b1; irq_i = 1'b0; slave_en = 1'b1; seq_mode = 1'b0;
    step(3);
    check("reset_bus", {20'd0, cyc_o, stb_o, we_o, adr_o, dat_o}, 32'd0);
    check("reset_rsp", {21'd0, rsp_valid_o, rsp_err_o, rsp_nak_o, rsp_dat_o}, 32'd0);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_ready", {31'd0, cmd_ready_o}, 32'd1);
    rst_i = 1'b0;
    step(2);

    // Write then read back through the slave memory.
    clear_mon();
    push_cmd(2'd0, 2'd1, 8'hA5); exp_q.push_back({8'h00, 1'b0, 1'b0});
    push_cmd(2'd1, 2'd1, 8'h00); exp_q.push_back({8'hA5, 1'b0, 1'b0});
    wait_idle();
    check("wr_rd_pulses", bus_q.size(), 32'd2);
    check("wr_attr", {21'd0, bus_q[0]}, {21'd0, 1'b1, 2'd1, 8'hA5});
    check("rd_attr", {21'd0, bus_q[1][10:8]}, {29'd0, 1'b0, 2'd1});
    check("wr_len", len_q[0], 32'd1);
    check("rd_len", len_q[1], 32'd1);
    check("b2b_gap", gap_q[1], 32'd3);

    // Latency: pop in the cycle after acceptance, response 3 cycles after cyc_o.
    push_cmd(2'd3, 2'd1, 8'h00); exp_q.push_back({8'hA5, 1'b0, 1'b0});
    n = 0;
    while (!cyc_o && n < 20) begin step(1); n++; end
    check("cyc_latency", n, 32'd1);
    n = 0;
    while (!rsp_valid_o && n < 20) begin step(1); n++; end
    check("rsp_latency", n, 32'd3);
    wait_idle();

    // Ack timeout.
    clear_mon();
    slave_en = 1'b0;
    push_cmd(2'd1, 2'd3, 8'h00); exp_q.push_back({8'h00, 1'b1, 1'b0});
    wait_idle();
    slave_en = 1'b1;
    check("to_pulses", bus_q.size(), 32'd1);
    check("to_len", len_q[0], 32'd4);

    // IRQ_READ with NAK bit set in the status byte.
    push_cmd(2'd0, 2'd2, 8'hC0); exp_q.push_back({8'h00, 1'b0, 1'b0});
    wait_idle();
    clear_mon();
    push_cmd(2'd2, 2'd0, 8'h00); exp_q.push_back({8'hC0, 1'b0, 1'b1});
    step(20);
    check("irq_no_bus", bus_q.size(), 32'd0);
    check("irq_busy", {31'd0, busy_o}, 32'd1);
    irq_i = 1'b1;
    wait_idle();
    irq_i = 1'b0;
    check("irq_pulses", bus_q.size(), 32'd1);
    check("irq_attr", {21'd0, bus_q[0][10:8]}, {29'd0, 1'b0, 2'd2});

    // IRQ_READ with status 0x80: no NAK.
    push_cmd(2'd0, 2'd2, 8'h80); exp_q.push_back({8'h00, 1'b0, 1'b0});
    wait_idle();
    push_cmd(2'd2, 2'd1, 8'h00); exp_q.push_back({8'h80, 1'b0, 1'b0});
    step(5);
    irq_i = 1'b1;
    wait_idle();
    irq_i = 1'b0;

    // Back-pressure: response FIFO stalls the engine after 2 commands.
    clear_mon();
    seq_mode = 1'b1;
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_cmd(2'd1, 2'(i), 8'h00);
      exp_q.push_back({2'(i), 6'(i), 1'b0, 1'b0});
    end
    step(30);
    check("bp_pulses", bus_q.size(), 32'd2);
    check("bp_ready_low", {31'd0, cmd_ready_o}, 32'd0);
    check("bp_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);

    // Push held on a full FIFO while the stall is released.
    cmd_valid_i = 1'b1; cmd_op_i = 2'd1; cmd_adr_i = 2'd2; cmd_dat_i = 8'h00;
    rsp_ready_i = 1'b1;
    step(1);
    check("full_ready_pop_cycle", {31'd0, cmd_ready_o}, 32'd0);
    step(1);
    check("full_ready_after_pop", {31'd0, cmd_ready_o}, 32'd1);
    check("full_cyc_after_pop", {31'd0, cyc_o}, 32'd1);
    step(1);
    cmd_valid_i = 1'b0;
    exp_q.push_back({2'd2, 6'd6, 1'b0, 1'b0});
    wait_idle();
    check("drain_pulses", bus_q.size(), 32'd7);
    for (int i = 0; i < 7; i++) check("drain_order_adr", {30'd0, bus_q[i][9:8]}, {30'd0, 2'(i)});
    seq_mode = 1'b0;

    // Reset in the middle of a bus cycle drops everything.
    clear_mon();
    slave_en = 1'b0;
    push_cmd(2'd1, 2'd0, 8'h00);
    push_cmd(2'd1, 2'd1, 8'h00);
    n = 0;
    while (!cyc_o && n < 20) begin step(1); n++; end
    check("rst_bus_seen", {31'd0, cyc_o}, 32'd1);
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    check("rst_cyc_stb", {30'd0, cyc_o, stb_o}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready_o}, 32'd1);
    step(10);
    check("rst_no_new_bus", bus_q.size(), 32'd1);
    check("rst_still_empty", {31'd0, rsp_valid_o}, 32'd0);
    slave_en = 1'b1;

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
